// File: rtl/sram_1r1w_be_init.sv
// One-read/one-write register-array SRAM with byte enables, write-first forwarding,
// 1- or 2-cycle read latency and a hardware zero-fill sequence after reset.
module sram_1r1w_be_init #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LATENCY = 1,
  parameter int BE_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [BE_WIDTH-1:0]   write_be,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] read_data
);

  generate
    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
      $error("sram_1r1w_be_init: DATA_WIDTH must be a positive multiple of 8");
    end
    if (BE_WIDTH != DATA_WIDTH / 8) begin : g_bad_be
      $error("sram_1r1w_be_init: BE_WIDTH must equal DATA_WIDTH/8");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
      $error("sram_1r1w_be_init: READ_LATENCY must be 1 or 2");
    end
    if ((DEPTH < 2) || ((64'd1 << ADDR_WIDTH) < 64'(DEPTH))) begin : g_bad_depth
      $error("sram_1r1w_be_init: need DEPTH >= 2 and 2**ADDR_WIDTH >= DEPTH");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   init_cnt_reg, init_cnt_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_acc;
  logic                    rd_acc;
  logic                    collision;
  logic [DATA_WIDTH-1:0]   wr_old;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    read_valid_reg;
  logic [DATA_WIDTH-1:0]   read_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == LAST_ENTRY) begin
          state_next    = ST_READY;
          init_cnt_next = '0;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next    = ST_INIT;
        init_cnt_next = '0;
      end
    endcase
  end

  assign init_done   = (state_reg == ST_READY);
  assign wr_in_range = ({1'b0, write_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_EXT);
  assign wr_acc      = init_done && write_en && wr_in_range;
  assign rd_acc      = init_done && read_en;
  assign wr_old      = mem[write_addr];

  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_byte_merge
      assign wr_merged[8*gi +: 8] = write_be[gi] ? write_data[8*gi +: 8] : wr_old[8*gi +: 8];
    end
  endgenerate

  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (!init_done) begin
      mem[init_cnt_reg] <= '0;
    end else if (wr_acc) begin
      mem[write_addr] <= wr_merged;
    end
  end

  // Write-first: a same-address write in the accept cycle is visible to the read.
  assign collision = wr_acc && (write_addr == read_addr);

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = collision ? wr_merged : mem[read_addr];
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          read_valid_reg <= 1'b0;
          read_data_reg  <= '0;
        end else begin
          read_valid_reg <= rd_acc;
          if (rd_acc) begin
            read_data_reg <= rd_word;
          end
        end
      end
    end else begin : g_lat2
      logic                  p1_valid_reg;
      logic [DATA_WIDTH-1:0] p1_data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p1_valid_reg   <= 1'b0;
          p1_data_reg    <= '0;
          read_valid_reg <= 1'b0;
          read_data_reg  <= '0;
        end else begin
          p1_valid_reg   <= rd_acc;
          if (rd_acc) begin
            p1_data_reg <= rd_word;
          end
          read_valid_reg <= p1_valid_reg;
          if (p1_valid_reg) begin
            read_data_reg <= p1_data_reg;
          end
        end
      end
    end
  endgenerate

  assign read_valid = read_valid_reg;
  assign read_data  = read_data_reg;

endmodule

// File: tb/tb_sram_1r1w_be_init.sv
// Bench for sram_1r1w_be_init: a 64-deep latency-1 instance and a 48-deep latency-2
// instance, checked every cycle against a word-level model plus directed vectors.
module tb_sram_1r1w_be_init;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done [2];
  logic        we [2];
  logic        re [2];
  logic        rv [2];
  logic [5:0]  wa [2];
  logic [5:0]  ra [2];
  logic [63:0] wd [2];
  logic [63:0] rd [2];
  logic [7:0]  be [2];

  sram_1r1w_be_init #(
    .DATA_WIDTH(64), .DEPTH(64), .ADDR_WIDTH(6), .READ_LATENCY(1)
  ) u_d64_l1 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done[0]),
    .write_en(we[0]), .write_addr(wa[0]), .write_data(wd[0]), .write_be(be[0]),
    .read_en(re[0]), .read_addr(ra[0]), .read_valid(rv[0]), .read_data(rd[0])
  );

  sram_1r1w_be_init #(
    .DATA_WIDTH(64), .DEPTH(48), .ADDR_WIDTH(6), .READ_LATENCY(2)
  ) u_d48_l2 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done[1]),
    .write_en(we[1]), .write_addr(wa[1]), .write_data(wd[1]), .write_be(be[1]),
    .read_en(re[1]), .read_addr(ra[1]), .read_valid(rv[1]), .read_data(rd[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
    bit          has_exp;
    logic [63:0] exp;
  } res_t;

  typedef struct {
    int          sel;
    bit          w;
    logic [5:0]  wa_v;
    logic [63:0] wd_v;
    logic [7:0]  be_v;
    bit          r;
    logic [5:0]  ra_v;
    bit          has;
    logic [63:0] exp;
  } vec_t;

  res_t        q0 [$];
  res_t        q1 [$];
  logic [63:0] m_mem [2][64];
  int          m_cnt [2];
  logic [63:0] m_last [2];
  int          m_depth [2] = '{64, 48};
  int          m_lat [2]   = '{1, 2};
  bit          dir_has [2];
  logic [63:0] dir_exp [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        vt [$];

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b0; re[i] = 1'b0; wa[i] = '0; ra[i] = '0;
      wd[i] = '0; be[i] = '0; dir_has[i] = 1'b0; dir_exp[i] = '0;
    end
  endtask

  task automatic drive(input int i, input bit w, input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] b, input bit r, input logic [5:0] rav,
                       input bit h, input logic [63:0] e);
    we[i] = w; wa[i] = a; wd[i] = d; be[i] = b;
    re[i] = r; ra[i] = rav; dir_has[i] = h; dir_exp[i] = e;
  endtask

  // Word-level model of what the coming rising edge does to each instance.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      res_t r;
      if (m_cnt[i] < m_depth[i]) begin
        m_mem[i][m_cnt[i]] = '0;
        m_cnt[i]++;
      end else begin
        if (we[i] && (int'(wa[i]) < m_depth[i])) begin
          for (int b = 0; b < 8; b++) begin
            if (be[i][b]) m_mem[i][wa[i]][8*b +: 8] = wd[i][8*b +: 8];
          end
        end
        if (re[i]) begin
          r.due     = cyc + m_lat[i];
          r.data    = (int'(ra[i]) < m_depth[i]) ? m_mem[i][ra[i]] : 64'd0;
          r.has_exp = dir_has[i];
          r.exp     = dir_exp[i];
          if (i == 0) q0.push_back(r); else q1.push_back(r);
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit   have;
      res_t r;
      chk("init_done", i, {63'd0, init_done[i]}, (m_cnt[i] >= m_depth[i]) ? 64'd1 : 64'd0);
      if (i == 0) have = (q0.size() > 0) && (q0[0].due == cyc);
      else        have = (q1.size() > 0) && (q1[0].due == cyc);
      if (have) begin
        if (i == 0) r = q0.pop_front(); else r = q1.pop_front();
        chk("read_valid", i, {63'd0, rv[i]}, 64'd1);
        chk("read_data", i, rd[i], r.data);
        if (r.has_exp) chk("vector_data", i, rd[i], r.exp);
        m_last[i] = r.data;
        $display("inst%0d cyc %0d read result %h", i, cyc, rd[i]);
      end else begin
        chk("read_valid_idle", i, {63'd0, rv[i]}, 64'd0);
        chk("read_data_hold", i, rd[i], m_last[i]);
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_last[i] = '0;
    end
  endtask

  task automatic reset_checks();
    for (int i = 0; i < 2; i++) begin
      chk("rst_read_valid", i, {63'd0, rv[i]}, 64'd0);
      chk("rst_read_data", i, rd[i], 64'd0);
      chk("rst_init_done", i, {63'd0, init_done[i]}, 64'd0);
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 64; a++) m_mem[i][a] = '0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // INIT: requests are ignored, including a write to entry 5
    for (int k = 0; k < 64; k++) begin
      idle_all();
      for (int i = 0; i < 2; i++)
        if (m_cnt[i] < m_depth[i]) drive(i, 1, 6'd5, '1, 8'hFF, 1, 6'd5, 0, '0);
      step();
    end

    // Every address reads back zero (out-of-range on the 48-deep instance too)
    for (int a = 0; a < 64; a++) begin
      idle_all();
      drive(0, 0, '0, '0, '0, 1, 6'(a), 1, 64'd0);
      drive(1, 0, '0, '0, '0, 1, 6'(a), 1, 64'd0);
      step();
    end
    idle_all();
    repeat (3) step();

    vt.push_back('{0, 1, 6'd3, 64'h1111_2222_3333_4444, 8'hFF, 0, 6'd0, 0, 64'd0});
    vt.push_back('{0, 1, 6'd3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 6'd0, 0, 64'd0});
    vt.push_back('{0, 0, 6'd0, 64'd0, 8'h00, 1, 6'd3, 1, 64'h1111_2222_CCCC_DDDD});
    vt.push_back('{0, 1, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 1, 6'd7, 1, 64'hFFFF_FFFF_0000_0000});
    vt.push_back('{0, 0, 6'd0, 64'd0, 8'h00, 1, 6'd7, 1, 64'hFFFF_FFFF_0000_0000});
    vt.push_back('{0, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 1, 6'd0, 64'd10, 8'hFF, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 1, 6'd1, 64'd11, 8'hFF, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 1, 6'd2, 64'd12, 8'hFF, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 1, 6'd0, 1, 64'd10});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 1, 6'd1, 1, 64'd11});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 1, 6'd2, 1, 64'd12});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 1, 6'd50, 64'h5A, 8'hFF, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 1, 6'd50, 1, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 1, 6'd2, 1, 64'd12});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});
    vt.push_back('{1, 0, 6'd0, 64'd0, 8'h00, 0, 6'd0, 0, 64'd0});

    foreach (vt[n]) begin
      idle_all();
      drive(vt[n].sel, vt[n].w, vt[n].wa_v, vt[n].wd_v, vt[n].be_v,
            vt[n].r, vt[n].ra_v, vt[n].has, vt[n].exp);
      step();
    end
    idle_all();
    repeat (3) step();

    // Random traffic; addresses span the full 6-bit range
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++)
        drive(i, 1'($urandom_range(1)), 6'($urandom_range(63)), {$urandom, $urandom},
              8'($urandom), 1'($urandom_range(1)), 6'($urandom_range(63)), 0, '0);
      step();
    end
    idle_all();
    repeat (3) step();

    // Known data before the mid-read reset
    idle_all();
    drive(0, 1, 6'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, '0, 0, '0);
    drive(1, 1, 6'd0, 64'hCAFE_F00D_8899_AABB, 8'hFF, 0, '0, 0, '0);
    step();
    idle_all();
    repeat (3) step();

    // Read accepted, then reset before the latency-2 result lands
    drive(0, 0, '0, '0, '0, 1, 6'd3, 1, 64'hDEAD_BEEF_0123_4567);
    drive(1, 0, '0, '0, '0, 1, 6'd0, 1, 64'hCAFE_F00D_8899_AABB);
    step();
    idle_all();
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    repeat (2) begin
      @(posedge clk);
      cyc++;
      #1;
      reset_checks();
    end
    rst_n = 1'b1;
    repeat (64) step();

    drive(0, 0, '0, '0, '0, 1, 6'd3, 1, 64'd0);
    drive(1, 0, '0, '0, '0, 1, 6'd0, 1, 64'd0);
    step();
    idle_all();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
